mips_cpu_multdiv: RTL

- Iterative multiply/divide unit in the execute stage, alongside mips_cpu_ALU.
- Takes the same register operands (a = rs, b = rt) and produces the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Uses a start/busy/done handshake. The control path stalls on busy before issuing MFHI/MFLO or a new mult/div.

---
 rtl/mips_cpu_multdiv.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mips_cpu_multdiv.sv
// Iterative multiply/divide unit producing the architectural HI/LO registers.
// One multiplier bit (LSB first) or one quotient bit (MSB first) per cycle,
// 32 iterations, with sign correction applied on the completion edge.
module mips_cpu_multdiv #(
    parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;          // product accumulator, or {remainder, dividend/quotient}
    logic [63:0] mcand_q, mcand_d;      // shifted multiplicand; raw dividend in [31:0] for divides
    logic [31:0] mplier_q, mplier_d;    // multiplier (shifted right) or divisor magnitude
    logic [4:0]  count_q, count_d;
    logic        is_div_q, is_div_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_signed, sa, sb;
    logic [31:0] mag_a, mag_b;
    logic [63:0] mul_acc, div_acc, step_acc, product;
    logic [32:0] rem_shift, diff;
    logic [31:0] quot, rem;

    // Next-state, datapath iteration and result write-back.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        // Operand conditioning for a new request (ops 0 and 2 are the signed ones).
        is_signed = ~op[0];
        sa        = is_signed & a[31];
        sb        = is_signed & b[31];
        mag_a     = sa ? (~a + 32'd1) : a;
        mag_b     = sb ? (~b + 32'd1) : b;

        // One shift-add multiply step.
        mul_acc   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

        // One restoring-divide step: bring down the next dividend bit, trial subtract.
        rem_shift = {acc_q[63:32], acc_q[31]};
        diff      = rem_shift - {1'b0, mplier_q};
        div_acc   = diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                             : {diff[31:0],      acc_q[30:0], 1'b1};
        step_acc  = is_div_q ? div_acc : mul_acc;

        // Sign correction of the final step's result.
        product   = (sign_a_q ^ sign_b_q) ? (~step_acc + 64'd1) : step_acc;
        quot      = (sign_a_q ^ sign_b_q) ? (~step_acc[31:0] + 32'd1) : step_acc[31:0];
        rem       = sign_a_q ? (~step_acc[63:32] + 32'd1) : step_acc[63:32];

        case (state_q)
            S_RUN: begin
                acc_d   = step_acc;
                count_d = count_q + 5'd1;
                if (!is_div_q) begin
                    mcand_d  = {mcand_q[62:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[31:1]};
                end
                if (count_q == 5'd31) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end else if (div0_q) begin
                        hi_d = mcand_q[31:0];
                        lo_d = DIV0_LO;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept requests; DONE falls back to IDLE.
                state_d = S_IDLE;
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d  = S_RUN;
                            count_d  = 5'd0;
                            is_div_d = op[1];
                            sign_a_d = sa;
                            sign_b_d = sb;
                            div0_d   = op[1] & (b == 32'd0);
                            mplier_d = mag_b;
                            if (op[1]) begin
                                acc_d   = {32'd0, mag_a};
                                mcand_d = {32'd0, a};
                            end else begin
                                acc_d   = 64'd0;
                                mcand_d = {32'd0, mag_a};
                            end
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            count_q  <= 5'd0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
